// File: rtl/step_pos_ctrl_if.sv
// Target request channel for step_pos_ctrl.
// The master supplies a signed step target; the slave accepts it when ready.
interface step_pos_ctrl_if;
  logic signed [7:0] tgt_pos;
  logic              tgt_valid;
  logic              tgt_ready;

  modport master (
    output tgt_pos,
    output tgt_valid,
    input  tgt_ready
  );

  modport slave (
    input  tgt_pos,
    input  tgt_valid,
    output tgt_ready
  );
endinterface

// File: rtl/step_pos_ctrl.sv
// Stepper position controller: walks cur_pos one step per move cycle toward a latched target.
// Optional macro STEP_POS_DWELL_EN inserts one idle DWELL cycle between consecutive steps.
module step_pos_ctrl (
  input  logic              drv_clk,
  input  logic              reset,
  step_pos_ctrl_if.slave    tgt,
  input  logic              abort,
  output logic              forward,
  output logic              reverse,
  output logic signed [7:0] cur_pos,
  output logic              busy,
  output logic              at_target
);

`ifdef STEP_POS_DWELL_EN
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FWD   = 3'd1,
    REV   = 3'd2,
    DONE  = 3'd3,
    DWELL = 3'd4
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    REV  = 2'd2,
    DONE = 2'd3
  } state_t;
`endif

  state_t            state;
  state_t            state_next;
  logic signed [7:0] tgt_q;
  logic signed [7:0] pos_inc;
  logic signed [7:0] pos_dec;
  logic              accept;

  // Moves only ever approach an in-range target, so these never wrap in use.
  assign pos_inc = cur_pos + 8'sd1;
  assign pos_dec = cur_pos - 8'sd1;
  assign accept  = (state == IDLE) && tgt.tgt_valid;

  always_ff @(posedge drv_clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (tgt.tgt_valid) begin
          if (tgt.tgt_pos > cur_pos) begin
            state_next = FWD;
          end else if (tgt.tgt_pos < cur_pos) begin
            state_next = REV;
          end else begin
            state_next = DONE;
          end
        end
      end
      FWD: begin
        if (abort) begin
          state_next = IDLE;
        end else if (pos_inc == tgt_q) begin
          state_next = DONE;
        end else begin
`ifdef STEP_POS_DWELL_EN
          state_next = DWELL;
`else
          state_next = FWD;
`endif
        end
      end
      REV: begin
        if (abort) begin
          state_next = IDLE;
        end else if (pos_dec == tgt_q) begin
          state_next = DONE;
        end else begin
`ifdef STEP_POS_DWELL_EN
          state_next = DWELL;
`else
          state_next = REV;
`endif
        end
      end
`ifdef STEP_POS_DWELL_EN
      // DWELL is only entered with the target still away from cur_pos.
      DWELL: begin
        if (abort) begin
          state_next = IDLE;
        end else if (cur_pos < tgt_q) begin
          state_next = FWD;
        end else begin
          state_next = REV;
        end
      end
`endif
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // A step ending on an abort edge still counts toward cur_pos.
  always_ff @(posedge drv_clk) begin
    if (!reset) begin
      cur_pos <= 8'sd0;
      tgt_q   <= 8'sd0;
    end else begin
      if (accept) begin
        tgt_q <= tgt.tgt_pos;
      end
      if (state == FWD) begin
        cur_pos <= pos_inc;
      end else if (state == REV) begin
        cur_pos <= pos_dec;
      end
    end
  end

  always_comb begin
    forward       = 1'b0;
    reverse       = 1'b0;
    at_target     = 1'b0;
    busy          = 1'b1;
    tgt.tgt_ready = 1'b0;
    case (state)
      IDLE: begin
        busy          = 1'b0;
        tgt.tgt_ready = 1'b1;
      end
      FWD:     forward   = 1'b1;
      REV:     reverse   = 1'b1;
      DONE:    at_target = 1'b1;
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_step_pos_ctrl.sv
// Scoreboard bench for step_pos_ctrl: each accepted move queues its per-cycle expected outputs.
// Honours STEP_POS_DWELL_EN so expectations match either build.
module tb_step_pos_ctrl;

  typedef struct packed {
    logic              fwd;
    logic              rev;
    logic              at;
    logic              bsy;
    logic signed [7:0] pos;
  } exp_t;

  logic              drv_clk;
  logic              reset;
  logic              abort;
  logic              forward;
  logic              reverse;
  logic signed [7:0] cur_pos;
  logic              busy;
  logic              at_target;

  step_pos_ctrl_if tgt_bus ();

  step_pos_ctrl dut (
    .drv_clk   (drv_clk),
    .reset     (reset),
    .tgt       (tgt_bus),
    .abort     (abort),
    .forward   (forward),
    .reverse   (reverse),
    .cur_pos   (cur_pos),
    .busy      (busy),
    .at_target (at_target)
  );

  int   checks;
  int   failures;
  int   model_pos;
  exp_t exp_q[$];

  initial drv_clk = 1'b0;
  always #5 drv_clk = ~drv_clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Expected outputs for every cycle from the one after acceptance through DONE.
  task automatic push_move(input int target);
    exp_t e;
    int   n;
    int   dir;
    n   = (target > model_pos) ? target - model_pos : model_pos - target;
    dir = (target > model_pos) ? 1 : -1;
    for (int k = 0; k < n; k++) begin
      e.fwd = (dir > 0);
      e.rev = (dir < 0);
      e.at  = 1'b0;
      e.bsy = 1'b1;
      e.pos = 8'(model_pos + dir * k);
      exp_q.push_back(e);
`ifdef STEP_POS_DWELL_EN
      if (k < n - 1) begin
        e.fwd = 1'b0;
        e.rev = 1'b0;
        e.pos = 8'(model_pos + dir * (k + 1));
        exp_q.push_back(e);
      end
`endif
    end
    e.fwd = 1'b0;
    e.rev = 1'b0;
    e.at  = 1'b1;
    e.bsy = 1'b1;
    e.pos = 8'(target);
    exp_q.push_back(e);
    model_pos = target;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(negedge drv_clk);
    reset = 1'b1;
    model_pos = 0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    exp_t obs;
    reset             = 1'b0;
    abort             = 1'b1;
    tgt_bus.tgt_valid = 1'b1;
    tgt_bus.tgt_pos   = 8'sd5;
    repeat (2) @(negedge drv_clk);
    obs = {forward, reverse, at_target, busy, cur_pos};
    checks++;
    if (obs !== 12'h000) begin
      $display("[TB] FAIL reset_outputs: got %b want %b", obs, 12'h000);
      failures++;
    end
    checks++;
    if (tgt_bus.tgt_ready !== 1'b1) begin
      $display("[TB] FAIL reset_ready: got %b want 1", tgt_bus.tgt_ready);
      failures++;
    end
    reset             = 1'b1;
    abort             = 1'b0;
    tgt_bus.tgt_valid = 1'b0;
    @(negedge drv_clk);
    obs = {forward, reverse, at_target, busy, cur_pos};
    checks++;
    if (obs !== 12'h000 || tgt_bus.tgt_ready !== 1'b1) begin
      $display("[TB] FAIL reset_release_idle: got %b ready=%b want %b ready=1", obs, tgt_bus.tgt_ready, 12'h000);
      failures++;
    end
    model_pos = 0;
  endtask

  task automatic test_move(input string name, input int target);
    exp_t e;
    exp_t obs;
    int   cyc;
    tgt_bus.tgt_pos   = 8'(target);
    tgt_bus.tgt_valid = 1'b1;
    push_move(target);
    @(negedge drv_clk);
    tgt_bus.tgt_valid = 1'b0;
    cyc = 0;
    while (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      obs = {forward, reverse, at_target, busy, cur_pos};
      checks++;
      if (obs !== e) begin
        $display("[TB] FAIL %s cycle %0d: got f/r/at/busy=%b pos=%0d want %b pos=%0d",
                 name, cyc, obs[11:8], $signed(obs.pos), e[11:8], $signed(e.pos));
        failures++;
      end
      cyc++;
      @(negedge drv_clk);
    end
    checks++;
    if (tgt_bus.tgt_ready !== 1'b1 || busy !== 1'b0 || cur_pos !== 8'(target)) begin
      $display("[TB] FAIL %s end_idle: got ready=%b busy=%b pos=%0d want ready=1 busy=0 pos=%0d",
               name, tgt_bus.tgt_ready, busy, $signed(cur_pos), target);
      failures++;
    end
  endtask

  task automatic test_abort();
    exp_t e;
    exp_t obs;
    int   cyc;
    int   fwd_seen;
    do_reset();
    tgt_bus.tgt_pos   = 8'sd20;
    tgt_bus.tgt_valid = 1'b1;
    push_move(20);
    @(negedge drv_clk);
    tgt_bus.tgt_valid = 1'b0;
    cyc      = 0;
    fwd_seen = 0;
    while (exp_q.size() > 0 && fwd_seen < 5) begin
      e   = exp_q.pop_front();
      obs = {forward, reverse, at_target, busy, cur_pos};
      checks++;
      if (obs !== e) begin
        $display("[TB] FAIL abort_move cycle %0d: got f/r/at/busy=%b pos=%0d want %b pos=%0d",
                 cyc, obs[11:8], $signed(obs.pos), e[11:8], $signed(e.pos));
        failures++;
      end
      if (e.fwd) fwd_seen++;
      // A competing target while busy must be dropped.
      if (cyc == 1) begin
        tgt_bus.tgt_pos   = -8'sd3;
        tgt_bus.tgt_valid = 1'b1;
      end else if (cyc == 3) begin
        tgt_bus.tgt_valid = 1'b0;
      end
      if (fwd_seen == 5) abort = 1'b1;
      cyc++;
      @(negedge drv_clk);
    end
    abort             = 1'b0;
    tgt_bus.tgt_valid = 1'b0;
    exp_q.delete();
    model_pos = 5;
    repeat (2) begin
      obs = {forward, reverse, at_target, busy, cur_pos};
      checks++;
      if (obs !== {4'b0000, 8'sd5} || tgt_bus.tgt_ready !== 1'b1) begin
        $display("[TB] FAIL abort_idle: got f/r/at/busy=%b pos=%0d ready=%b want 0000 pos=5 ready=1",
                 obs[11:8], $signed(obs.pos), tgt_bus.tgt_ready);
        failures++;
      end
      @(negedge drv_clk);
    end
  endtask

  task automatic test_abort_in_idle();
    exp_t e;
    exp_t obs;
    int   cyc;
    abort             = 1'b1;
    tgt_bus.tgt_pos   = 8'sd7;
    tgt_bus.tgt_valid = 1'b1;
    push_move(7);
    @(negedge drv_clk);
    abort             = 1'b0;
    tgt_bus.tgt_valid = 1'b0;
    cyc = 0;
    while (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      obs = {forward, reverse, at_target, busy, cur_pos};
      checks++;
      if (obs !== e) begin
        $display("[TB] FAIL abort_idle_accept cycle %0d: got f/r/at/busy=%b pos=%0d want %b pos=%0d",
                 cyc, obs[11:8], $signed(obs.pos), e[11:8], $signed(e.pos));
        failures++;
      end
      // Abort during DONE must not suppress completion or the return to IDLE.
      abort = e.at;
      cyc++;
      @(negedge drv_clk);
    end
    abort = 1'b0;
    checks++;
    if (tgt_bus.tgt_ready !== 1'b1 || cur_pos !== 8'sd7) begin
      $display("[TB] FAIL abort_idle_end: got ready=%b pos=%0d want ready=1 pos=7",
               tgt_bus.tgt_ready, $signed(cur_pos));
      failures++;
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    exp_t obs;
    int   cyc;
    tgt_bus.tgt_pos   = 8'sd9;
    tgt_bus.tgt_valid = 1'b1;
    push_move(9);
    @(negedge drv_clk);
    tgt_bus.tgt_valid = 1'b0;
    cyc = 0;
    while (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      obs = {forward, reverse, at_target, busy, cur_pos};
      checks++;
      if (obs !== e) begin
        $display("[TB] FAIL b2b_first cycle %0d: got f/r/at/busy=%b pos=%0d want %b pos=%0d",
                 cyc, obs[11:8], $signed(obs.pos), e[11:8], $signed(e.pos));
        failures++;
      end
      // Present the next target already during DONE; it must wait for IDLE.
      if (e.at) begin
        tgt_bus.tgt_pos   = 8'sd6;
        tgt_bus.tgt_valid = 1'b1;
      end
      cyc++;
      @(negedge drv_clk);
    end
    checks++;
    if (tgt_bus.tgt_ready !== 1'b1 || busy !== 1'b0 || cur_pos !== 8'sd9) begin
      $display("[TB] FAIL b2b_gap_idle: got ready=%b busy=%b pos=%0d want ready=1 busy=0 pos=9",
               tgt_bus.tgt_ready, busy, $signed(cur_pos));
      failures++;
    end
    push_move(6);
    @(negedge drv_clk);
    tgt_bus.tgt_valid = 1'b0;
    cyc = 0;
    while (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      obs = {forward, reverse, at_target, busy, cur_pos};
      checks++;
      if (obs !== e) begin
        $display("[TB] FAIL b2b_second cycle %0d: got f/r/at/busy=%b pos=%0d want %b pos=%0d",
                 cyc, obs[11:8], $signed(obs.pos), e[11:8], $signed(e.pos));
        failures++;
      end
      cyc++;
      @(negedge drv_clk);
    end
    checks++;
    if (tgt_bus.tgt_ready !== 1'b1 || cur_pos !== 8'sd6) begin
      $display("[TB] FAIL b2b_end: got ready=%b pos=%0d want ready=1 pos=6",
               tgt_bus.tgt_ready, $signed(cur_pos));
      failures++;
    end
  endtask

  task automatic test_reset_mid_move();
    exp_t e;
    exp_t obs;
    int   cyc;
    do_reset();
    tgt_bus.tgt_pos   = 8'sd10;
    tgt_bus.tgt_valid = 1'b1;
    push_move(10);
    @(negedge drv_clk);
    tgt_bus.tgt_valid = 1'b0;
    cyc = 0;
    while (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      obs = {forward, reverse, at_target, busy, cur_pos};
      checks++;
      if (obs !== e) begin
        $display("[TB] FAIL rst_mid_move cycle %0d: got f/r/at/busy=%b pos=%0d want %b pos=%0d",
                 cyc, obs[11:8], $signed(obs.pos), e[11:8], $signed(e.pos));
        failures++;
      end
      cyc++;
      if (e.fwd && e.pos == 8'sd3) begin
        reset = 1'b0;
        break;
      end
      @(negedge drv_clk);
    end
    @(negedge drv_clk);
    obs = {forward, reverse, at_target, busy, cur_pos};
    checks++;
    if (obs !== 12'h000 || tgt_bus.tgt_ready !== 1'b1) begin
      $display("[TB] FAIL rst_mid_outputs: got f/r/at/busy=%b pos=%0d ready=%b want 0000 pos=0 ready=1",
               obs[11:8], $signed(obs.pos), tgt_bus.tgt_ready);
      failures++;
    end
    reset = 1'b1;
    exp_q.delete();
    model_pos = 0;
    @(negedge drv_clk);
    obs = {forward, reverse, at_target, busy, cur_pos};
    checks++;
    if (obs !== 12'h000) begin
      $display("[TB] FAIL rst_mid_after: got %b want %b", obs, 12'h000);
      failures++;
    end
  endtask

  initial begin
    checks            = 0;
    failures          = 0;
    model_pos         = 0;
    abort             = 1'b0;
    reset             = 1'b0;
    tgt_bus.tgt_valid = 1'b0;
    tgt_bus.tgt_pos   = 8'sd0;
    test_reset();
    test_move("fwd_to_8", 8);
    test_move("rev_to_m16", -16);
    test_move("zero_move", -16);
    test_abort();
    test_abort_in_idle();
    test_back_to_back();
    test_reset_mid_move();
    test_move("after_reset_rev", -2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/step_pos_ctrl.md
STEP_POS_CTRL -- requirements
Module: step_pos_ctrl

Interface
REQ-001 The block SHALL have exactly one clock, and its reset SHALL be synchronous and active-low.
REQ-002 drv_clk  in  1  system/step clock; all state changes on its rising edge.
REQ-003 reset  in  1  synchronous active-low reset; sampled on rising drv_clk.
REQ-004 tgt_pos  in  8  signed target position in steps (-128..127).
REQ-005 tgt_valid  in  1  target request; held until accepted.
REQ-006 tgt_ready  out  1  high only in IDLE; a target is accepted on an edge with tgt_valid=1 and tgt_ready=1.
REQ-007 abort  in  1  cancels the move in progress.
REQ-008 forward  out  1  one-step-per-cycle forward request to the downstream stepper driver.
REQ-009 reverse  out  1  one-step-per-cycle reverse request to the downstream stepper driver.
REQ-010 cur_pos  out  8  signed tracked position.
REQ-011 busy  out  1  high in every state except IDLE.
REQ-012 at_target  out  1  one-cycle pulse when a move completes.

Function
REQ-013 States SHALL be: IDLE, FWD, REV, DWELL (present only with the macro), DONE.
REQ-014 Outputs SHALL be decoded from registered state: forward=(state==FWD), reverse=(state==REV), at_target=(state==DONE), tgt_ready=(state==IDLE).
REQ-015 forward and reverse SHALL never be high in the same cycle.
REQ-016 Target acceptance SHALL latch tgt_pos into an internal register.
REQ-017 On acceptance, next state SHALL be FWD if tgt>cur_pos, REV if tgt<cur_pos, or DONE if they are equal (zero-step move).
REQ-018 Latency: the first forward/reverse cycle SHALL be the cycle immediately after the acceptance edge.
REQ-019 At each edge ending a FWD cycle, cur_pos SHALL increment by 1; at each edge ending a REV cycle, cur_pos SHALL decrement by 1.
REQ-020 Signed 8-bit comparison SHALL be used throughout; cur_pos SHALL never wrap, because it moves only toward an in-range target.
REQ-021 After each step edge, the next state SHALL be DONE if the updated cur_pos equals tgt, otherwise the same direction state (or DWELL if the macro is defined).
REQ-022 The number of forward/reverse cycles per move SHALL be exactly |tgt - cur_pos at acceptance|.
REQ-023 DONE SHALL last exactly one cycle and then go to IDLE.
REQ-024 A new target SHALL NOT be accepted before the cycle after DONE.
REQ-025 tgt_valid SHALL be ignored whenever tgt_ready=0, with no queuing.
REQ-026 abort=1 in FWD, REV or DWELL SHALL move to IDLE at the next edge.
REQ-027 On abort: no further step, cur_pos holds its value at that edge including any step ending that cycle, and no at_target pulse.
REQ-028 abort SHALL be ignored in IDLE and DONE.
REQ-029 If tgt_valid and abort are both high in IDLE, the target SHALL be accepted.

Reset
REQ-030 reset=0 at an edge SHALL force state=IDLE, cur_pos=0 and the internal target register=0.
REQ-031 During reset, outputs SHALL be forward=0, reverse=0, busy=0, at_target=0, tgt_ready=1 from the next cycle.
REQ-032 Reset SHALL have priority over abort and tgt_valid.
REQ-033 Reset mid-move SHALL discard the move with no at_target pulse.

Configuration
REQ-034 Macro STEP_POS_DWELL_EN SHALL control dwell insertion.
REQ-035 With STEP_POS_DWELL_EN defined, one DWELL cycle (forward=reverse=0, busy=1) SHALL be inserted between consecutive steps of a move; none after the last step; an N-step move then takes 2N-1 cycles.
REQ-036 With STEP_POS_DWELL_EN undefined, the DWELL state SHALL be absent; steps are back-to-back and an N-step move takes N cycles.

Verification
REQ-037 Reset, then tgt_pos=8 accepted -> forward high for 8 consecutive cycles, cur_pos=8, one at_target pulse, then tgt_ready=1.
REQ-038 From cur_pos=8, tgt_pos=-16 -> reverse high for 24 cycles, cur_pos=-16, forward stays 0 throughout.
REQ-039 tgt_pos equal to cur_pos (-16) -> no steps; at_target pulses on the cycle after acceptance.
REQ-040 tgt_pos=20 from 0, abort on the 5th forward cycle -> cur_pos=5, IDLE, no at_target pulse; tgt_valid while busy is not accepted.
REQ-041 With STEP_POS_DWELL_EN defined, tgt_pos=4 from 0 -> forward pattern 1,0,1,0,1,0,1 (7 cycles), then at_target pulse.
REQ-042 reset=0 mid-move at cur_pos=3 -> next cycle cur_pos=0, forward=0, busy=0, tgt_ready=1.
